// File: rtl/rca_stream_feeder.sv
// Streaming front-end for a W-bit ripple-carry adder with carry chaining across multi-word operations.
// Latency: 2 cycles from operand push to res_valid (empty FIFO, idle output); 1 beat/cycle sustained.
// Backpressure: op_ready = !full (registered); result register holds while res_valid && !res_ready.

// Plain ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module bitNRCAdder #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic c;

  // Ripple the carry through N full-adder cells.
  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// Small synchronous FIFO with registered occupancy count; contents are not cleared on reset.
module rca_feeder_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign pop_dat = mem[rd_ptr];

  // Storage write; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping; push and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module rca_stream_feeder #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  input  logic         op_first,
  input  logic         op_last,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_last,
  output logic         err_seq
);
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         first;
    logic         last;
  } beat_t;

  typedef enum logic {IDLE, CHAIN} state_t;

  beat_t  in_beat;
  beat_t  head;
  logic   full;
  logic   empty;
  logic   push;
  logic   issue;
  state_t state;
  state_t state_nxt;
  logic   carry_q;
  logic   carry_nxt;
  logic   add_cin;
  logic   err_set;
  logic [W-1:0] add_sum;
  logic         add_cout;

  assign in_beat  = '{a: op_a, b: op_b, cin: op_cin, first: op_first, last: op_last};
  assign op_ready = !full;
  assign push     = op_valid && op_ready;
  assign issue    = !empty && (!res_valid || res_ready);

  rca_feeder_fifo #(.DW($bits(beat_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (in_beat),
    .pop      (issue),
    .pop_dat  (head),
    .full     (full),
    .empty    (empty)
  );

  bitNRCAdder #(.N(W)) u_add (
    .a    (head.a),
    .b    (head.b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry select and next-state: only a continuation beat inside a chain uses the stored carry;
  // any other beat starts afresh from its own op_cin and the last bit decides where we end up.
  always_comb begin
    state_nxt = state;
    carry_nxt = carry_q;
    add_cin   = head.cin;
    err_set   = 1'b0;
    if (state == CHAIN && !head.first) add_cin = carry_q;
    if (issue) begin
      err_set   = (state == IDLE) ? !head.first : head.first;
      state_nxt = head.last ? IDLE : CHAIN;
      carry_nxt = head.last ? 1'b0 : add_cout;
    end
  end

  // FSM, carry and sticky error registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      carry_q <= 1'b0;
      err_seq <= 1'b0;
    end else begin
      state   <= state_nxt;
      carry_q <= carry_nxt;
      if (err_set) err_seq <= 1'b1;
    end
  end

  // Result register: loads on issue, drops valid once accepted, otherwise holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
      res_last  <= 1'b0;
    end else if (issue) begin
      res_valid <= 1'b1;
      res_sum   <= add_sum;
      res_cout  <= add_cout;
      res_last  <= head.last;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rca_stream_feeder.sv
// Self-checking bench for rca_stream_feeder: directed beats with hand-computed results,
// expected results queued at stimulus time and compared by an independent output monitor.
module tb_rca_stream_feeder;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic         clk;
  logic         rst_n;
  logic         op_valid;
  logic         op_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_first;
  logic         op_last;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_last;
  logic         err_seq;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  rca_stream_feeder #(.W(W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .op_first  (op_first),
    .op_last   (op_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_last  (res_last),
    .err_seq   (err_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_result: got sum=%0h with nothing expected", res_sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_sum",  res_sum, e.sum);
        chk("res_cout", W'(res_cout), W'(e.cout));
        chk("res_last", W'(res_last), W'(e.last));
      end
    end
  end

  // Drive one beat at a negedge once op_ready is seen, queue its expected result.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic first, input logic last,
                      input logic [W-1:0] esum, input logic ecout);
    int guard = 0;
    while (!op_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!op_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL op_ready_timeout: got op_ready=0, expected 1 within 200 cycles");
    end
    op_valid = 1'b1;
    op_a = a; op_b = b; op_cin = cin; op_first = first; op_last = last;
    exp_q.push_back('{sum: esum, cout: ecout, last: last});
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while ((exp_q.size() != 0 || res_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_remaining", W'(exp_q.size()), '0);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0;
    op_first = 1'b0; op_last = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    chk("rst_res_valid", W'(res_valid), '0);
    chk("rst_op_ready",  W'(op_ready),  W'(1));
    chk("rst_err_seq",   W'(err_seq),   '0);
    chk("rst_res_sum",   res_sum,       '0);
    chk("rst_res_cout",  W'(res_cout),  '0);
    chk("rst_res_last",  W'(res_last),  '0);

    // 1: single beat with latency check
    send(64'd5, 64'd7, 1'b1, 1'b1, 1'b1, 64'd13, 1'b0);
    chk("lat_after_1", W'(res_valid), '0);
    @(negedge clk);
    chk("lat_after_2", W'(res_valid), W'(1));
    drain();

    // 2: wrap-around
    send(ONES, 64'd1, 1'b0, 1'b1, 1'b1, 64'd0, 1'b1);
    // 3: 128-bit add, carry crosses the word boundary
    send(ONES, 64'd1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
    send(64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 64'd1, 1'b0);
    // 192-bit add with carry propagating through a middle word
    send(ONES, ONES, 1'b1, 1'b1, 1'b0, ONES, 1'b1);
    send(64'd0, ONES, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1);
    send(64'd3, 64'd4, 1'b0, 1'b0, 1'b1, 64'd8, 1'b0);
    // Chain where the stored carry is 0 and the ignored op_cin is 1
    send(64'd1, 64'd1, 1'b0, 1'b1, 1'b0, 64'd2, 1'b0);
    send(ONES, 64'd0, 1'b1, 1'b0, 1'b1, ONES, 1'b0);
    drain();
    chk("err_clean", W'(err_seq), '0);

    // 4: backpressure, 2 in FIFO + 1 in result register
    res_ready = 1'b0;
    send(64'd10, 64'd20, 1'b0, 1'b1, 1'b1, 64'd30, 1'b0);
    send(64'd100, 64'd1, 1'b1, 1'b1, 1'b1, 64'd102, 1'b0);
    send(64'd7, 64'd8, 1'b0, 1'b1, 1'b1, 64'd15, 1'b0);
    chk("bp_op_ready", W'(op_ready), '0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", W'(res_valid), W'(1));
      chk("bp_hold_sum", res_sum, 64'd30);
      @(negedge clk);
    end
    res_ready = 1'b1;
    drain();

    // 5: protocol error, second beat restarts with its own op_cin
    send(ONES, 64'd1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
    send(64'd2, 64'd3, 1'b0, 1'b1, 1'b1, 64'd5, 1'b0);
    drain();
    chk("err_set", W'(err_seq), W'(1));
    send(64'd4, 64'd4, 1'b0, 1'b1, 1'b1, 64'd8, 1'b0);
    drain();
    chk("err_sticky", W'(err_seq), W'(1));

    // 6: reset mid-chain with a full FIFO and pending result
    res_ready = 1'b0;
    send(ONES, 64'd1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b1);
    send(64'd5, 64'd5, 1'b0, 1'b0, 1'b0, 64'd11, 1'b0);
    send(64'd6, 64'd6, 1'b0, 1'b0, 1'b0, 64'd12, 1'b0);
    chk("full_before_rst", W'(op_ready), '0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst6_res_valid", W'(res_valid), '0);
    chk("rst6_op_ready",  W'(op_ready),  W'(1));
    chk("rst6_err_seq",   W'(err_seq),   '0);
    res_ready = 1'b1;
    send(64'd1, 64'd1, 1'b0, 1'b1, 1'b1, 64'd2, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
